// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder for the pipeline load/store port
//
// Accepts one load/store at a time, performs a byte/half/word/double access
// on an internal doubleword array and returns data or an error.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous reset, active low
//   req_valid_i  request present            req_ready_o  responder can accept
//   req_we_i     1 = store, 0 = load        req_addr_i   byte address
//   req_wdata_i  store data, right-aligned  req_wid_i    funct3 width code
//   rsp_valid_o  response present           rsp_ready_i  requester takes response
//   rsp_rdata_o  load result (0 on store/error)
//   rsp_err_o    misaligned, out-of-range or illegal-width access
module dmem_responder #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [2:0]            req_wid_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int IDX_W     = $clog2(DEPTH);
    localparam int NBYTES    = DATA_WIDTH / 8;
    localparam int MEM_BYTES = DEPTH * NBYTES;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [2:0]              wid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic                    access;

    // Access operands: the live request when the access happens on the
    // acceptance edge (no wait states), otherwise the latched request.
    logic                    op_we;
    logic [ADDR_WIDTH-1:0]   op_addr;
    logic [DATA_WIDTH-1:0]   op_wdata;
    logic [2:0]              op_wid;

    logic [3:0]              op_size;
    logic [2:0]              op_off;
    logic [2:0]              op_align_mask;
    logic [IDX_W-1:0]        op_idx;
    logic [31:0]             op_end;
    logic                    op_err;
    logic [15:0]             op_be_base;
    logic [NBYTES-1:0]       op_be;
    logic [DATA_WIDTH-1:0]   op_word;
    logic [DATA_WIDTH-1:0]   op_shifted;
    logic [DATA_WIDTH-1:0]   op_load;
    logic [DATA_WIDTH-1:0]   op_wdata_sh;

    // FSM next state, handshake outputs and operand selection
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        accept      = 1'b0;
        access      = 1'b0;
        op_we       = we_q;
        op_addr     = addr_q;
        op_wdata    = wdata_q;
        op_wid      = wid_q;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = rst_ni;
                accept      = req_valid_i & rst_ni;
                op_we       = req_we_i;
                op_addr     = req_addr_i;
                op_wdata    = req_wdata_i;
                op_wid      = req_wid_i;
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        access  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Access decode: size, byte lanes, error detection, load extraction
    always_comb begin
        case (op_wid[1:0])
            2'd0:    op_size = 4'd1;
            2'd1:    op_size = 4'd2;
            2'd2:    op_size = 4'd4;
            default: op_size = 4'd8;
        endcase
        op_off        = op_addr[2:0];
        op_idx        = op_addr[3 +: IDX_W];
        op_align_mask = 3'(op_size - 4'd1);
        op_end        = 32'(op_addr) + 32'(op_size);
        op_err        = (op_wid == 3'b111)
                      | (op_we & op_wid[2])
                      | (|(op_off & op_align_mask))
                      | (op_end > 32'(MEM_BYTES));
        op_be_base    = (16'd1 << op_size) - 16'd1;
        op_be         = op_be_base[NBYTES-1:0] << op_off;
        op_word       = mem[op_idx];
        op_shifted    = op_word >> {op_off, 3'b000};
        op_wdata_sh   = op_wdata << {op_off, 3'b000};
        case (op_wid)
            3'b000:  op_load = {{(DATA_WIDTH-8){op_shifted[7]}},   op_shifted[7:0]};
            3'b001:  op_load = {{(DATA_WIDTH-16){op_shifted[15]}}, op_shifted[15:0]};
            3'b010:  op_load = {{(DATA_WIDTH-32){op_shifted[31]}}, op_shifted[31:0]};
            3'b011:  op_load = op_shifted;
            3'b100:  op_load = {{(DATA_WIDTH-8){1'b0}},  op_shifted[7:0]};
            3'b101:  op_load = {{(DATA_WIDTH-16){1'b0}}, op_shifted[15:0]};
            3'b110:  op_load = {{(DATA_WIDTH-32){1'b0}}, op_shifted[31:0]};
            default: op_load = '0;
        endcase
    end

    // State, counter, latched request and response registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wid_q   <= 3'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                wid_q   <= req_wid_i;
            end
            if (access) begin
                rdata_q <= (op_err || op_we) ? '0 : op_load;
                err_q   <= op_err;
            end
        end
    end

    // Storage is never cleared; a reset leaves the FSM in IDLE with
    // req_ready_o low, so an aborted access cannot reach this write.
    always_ff @(posedge clk_i) begin
        if (access && op_we && !op_err) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (op_be[b]) begin
                    mem[op_idx][8*b +: 8] <= op_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int DEPTH     = 4096;
    localparam int MEM_BYTES = DEPTH * 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: WAIT_CYCLES = 0, index 1: WAIT_CYCLES = 3
    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [15:0] req_addr  [2];
    logic [63:0] req_wdata [2];
    logic [2:0]  req_wid   [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [63:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int n_vec = 0;
    int n_bad = 0;

    // byte-level reference memory plus a flag for bytes the bench has written
    logic [7:0] mm    [2][MEM_BYTES];
    bit         known [2][MEM_BYTES];

    dmem_responder #(.DATA_WIDTH(64), .ADDR_WIDTH(16), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_wid_i(req_wid[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
    );

    dmem_responder #(.DATA_WIDTH(64), .ADDR_WIDTH(16), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_wid_i(req_wid[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
    );

    function automatic int wait_of(input int d);
        return (d == 1) ? 3 : 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference access: size from width code, error rules, little-endian
    // byte gather with sign/zero extension; stores update the byte array.
    task automatic model_access(input int d, input bit we, input int addr, input logic [63:0] wd,
                                input logic [2:0] wid, output logic [63:0] rd, output bit er,
                                output bit rd_known);
        int size;
        size     = 1 << wid[1:0];
        rd       = 64'd0;
        rd_known = 1'b1;
        er = (wid == 3'b111) || (we && wid[2]) || ((addr % size) != 0) || (addr + size > MEM_BYTES);
        if (!er) begin
            if (we) begin
                for (int i = 0; i < size; i++) begin
                    mm[d][addr+i]    = wd[8*i +: 8];
                    known[d][addr+i] = 1'b1;
                end
            end else begin
                for (int i = 0; i < size; i++) begin
                    rd[8*i +: 8] = mm[d][addr+i];
                    if (!known[d][addr+i]) rd_known = 1'b0;
                end
                if (!wid[2] && size < 8 && rd[8*size-1]) begin
                    for (int b = 8*size; b < 64; b++) rd[b] = 1'b1;
                end
            end
        end
    endtask

    task automatic xact(input int d, input bit we, input int addr, input logic [63:0] wd,
                        input logic [2:0] wid, input int hold);
        logic [63:0] erd;
        bit          eer;
        bit          ekn;
        int          cyc;
        int          lat;
        model_access(d, we, addr, wd, wid, erd, eer, ekn);
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = 16'(addr);
        req_wdata[d] = wd;
        req_wid[d]   = wid;
        cyc = 0;
        while (req_ready[d] !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("req_accept_in_time", 64'(cyc < 20), 64'd1);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_wdata[d] = 64'($urandom);
        lat = 1;
        while (rsp_valid[d] !== 1'b1 && lat < 40) begin
            check("busy_req_ready", 64'(req_ready[d]), 64'd0);
            @(negedge clk);
            lat++;
        end
        check("rsp_latency", 64'(lat), 64'(1 + wait_of(d)));
        for (int h = 0; h < hold; h++) begin
            check("held_valid", 64'(rsp_valid[d]), 64'd1);
            check("held_req_ready", 64'(req_ready[d]), 64'd0);
            check("held_err", 64'(rsp_err[d]), 64'(eer));
            if (ekn) check("held_rdata", rsp_rdata[d], erd);
            @(negedge clk);
        end
        rsp_ready[d] = 1'b1;
        check("rsp_valid", 64'(rsp_valid[d]), 64'd1);
        check("rsp_err", 64'(rsp_err[d]), 64'(eer));
        if (ekn) check("rsp_rdata", rsp_rdata[d], erd);
        check("resp_req_ready", 64'(req_ready[d]), 64'd0);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check("done_rsp_valid", 64'(rsp_valid[d]), 64'd0);
        check("done_req_ready", 64'(req_ready[d]), 64'd1);
    endtask

    task automatic directed(input int d);
        xact(d, 1'b1, 'h10, 64'h1122334455667788, 3'b011, 0);
        xact(d, 1'b0, 'h10, 64'd0, 3'b011, (d == 1) ? 4 : 0);
        xact(d, 1'b1, 'h13, 64'h80, 3'b000, 0);
        xact(d, 1'b0, 'h13, 64'd0, 3'b000, 0);
        xact(d, 1'b0, 'h13, 64'd0, 3'b100, 0);
        xact(d, 1'b0, 'h10, 64'd0, 3'b011, 0);
        xact(d, 1'b0, 'h12, 64'd0, 3'b010, 0);
        xact(d, 1'b1, 'h11, 64'hBEEF, 3'b001, 0);
        xact(d, 1'b0, 'h10, 64'd0, 3'b011, 0);
        xact(d, 1'b0, MEM_BYTES, 64'd0, 3'b011, 0);
        xact(d, 1'b0, MEM_BYTES - 8, 64'd0, 3'b011, 0);
        xact(d, 1'b0, 'h10, 64'd0, 3'b111, 0);
        xact(d, 1'b1, 'h18, 64'h0123456789ABCDEF, 3'b011, 0);
        xact(d, 1'b1, 'h18, 64'h55AA55AA, 3'b110, 0);
        xact(d, 1'b0, 'h18, 64'd0, 3'b011, 0);
    endtask

    task automatic random_ops(input int d, input int n);
        int          r;
        int          addr;
        int          size;
        bit          we;
        logic [2:0]  wid;
        logic [63:0] wd;
        for (int i = 0; i < n; i++) begin
            we   = 1'($urandom_range(0, 1));
            wid  = 3'($urandom_range(0, 7));
            size = 1 << wid[1:0];
            wd   = {$urandom, $urandom};
            r    = $urandom_range(0, 9);
            if (r < 7) begin
                addr = $urandom_range(0, 255);
                if ($urandom_range(0, 3) != 0) addr = addr & ~(size - 1);
            end else if (r < 9) begin
                addr = 'h7FF0 + $urandom_range(0, 31);
                if ($urandom_range(0, 1) != 0) addr = addr & ~(size - 1);
            end else begin
                addr = $urandom_range(0, 65535);
            end
            xact(d, we, addr, wd, wid, $urandom_range(0, 2));
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d]     = 1'b0;
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = 16'd0;
            req_wdata[d] = 64'd0;
            req_wid[d]   = 3'd0;
            rsp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_req_ready", 64'(req_ready[d]), 64'd0);
            check("reset_rsp_valid", 64'(rsp_valid[d]), 64'd0);
            check("reset_rsp_rdata", rsp_rdata[d], 64'd0);
            check("reset_rsp_err", 64'(rsp_err[d]), 64'd0);
            rst_n[d] = 1'b1;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) check("post_reset_req_ready", 64'(req_ready[d]), 64'd1);

        for (int d = 0; d < 2; d++) directed(d);

        // reset asserted while the 3-wait-state responder is in WAIT
        xact(1, 1'b1, 'h20, 64'd0, 3'b011, 0);
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 16'h20;
        req_wdata[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        req_wid[1]   = 3'b011;
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("abort_busy", 64'(req_ready[1]), 64'd0);
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        check("abort_rsp_valid", 64'(rsp_valid[1]), 64'd0);
        check("abort_req_ready", 64'(req_ready[1]), 64'd0);
        check("abort_rsp_err", 64'(rsp_err[1]), 64'd0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        @(negedge clk);
        check("abort_ready_after", 64'(req_ready[1]), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("abort_no_rsp", 64'(rsp_valid[1]), 64'd0);
            @(negedge clk);
        end
        xact(1, 1'b0, 'h20, 64'd0, 3'b011, 0);

        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 256; a += 8) begin
                xact(d, 1'b1, a, {$urandom, $urandom}, 3'b011, 0);
            end
            random_ops(d, 60);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
